trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, 256, number of 8-bit samples per trace; matches the display buffer width.
REQ-002 Parameter AUTO_TO, 1024, number of taken samples without a trigger before a forced trigger in auto mode.
REQ-003 Port clk  in  1  single system clock, all logic on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port sample_valid  in  1  qualifies sample for one clk cycle.
REQ-006 Port sample  in  8  unsigned ADC code.
REQ-007 Port trig_level  in  8  trigger threshold.
REQ-008 Port trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-009 Port decim  in  8  keep one valid sample in every decim+1.
REQ-010 Port arm  in  1  one-cycle start pulse.
REQ-011 Port run  in  1  1 = re-arm automatically after publish.
REQ-012 Port auto_mode  in  1  enables the AUTO_TO forced trigger.
REQ-013 Port vblnk  in  1  vertical blank from the VGA timing chain.
REQ-014 Port data  out  8 x DEPTH  published trace array, read by the display drawer.
REQ-015 Port busy  out  1  high whenever state is not IDLE.
REQ-016 Port frame_done  out  1  one-cycle pulse when data is updated.

Function
REQ-017 A sample is "taken" when sample_valid=1 and dec_cnt=0.
  - dec_cnt counts valid samples and wraps to 0 after reaching decim; decim=0 takes every valid sample.
  - dec_cnt clears on entry to WAIT_TRIG.
REQ-018 FSM states are IDLE, WAIT_TRIG, CAPTURE and PUBLISH.
  - IDLE -> WAIT_TRIG on arm.
  - arm in any other state is ignored.
REQ-019 Trigger conditions on a taken sample are evaluated against prev, the previous taken sample.
  - Rising: prev < trig_level and sample >= trig_level.
  - Falling: prev > trig_level and sample <= trig_level.
  - No trigger is possible until prev is valid (the first taken sample after entering WAIT_TRIG only loads prev).
REQ-020 In WAIT_TRIG, to_cnt counts taken samples.
  - When auto_mode=1 and to_cnt reaches AUTO_TO-1, the current taken sample acts as the trigger.
  - A simultaneous real trigger and timeout behaves identically to a real trigger.
REQ-021 The trigger sample is written to internal buffer index 0 and the FSM moves to CAPTURE with wr_idx=1.
REQ-022 In CAPTURE, each taken sample is written at wr_idx and wr_idx increments.
  - After the write to index DEPTH-1, the FSM moves to PUBLISH.
  - wr_idx never wraps inside a capture.
REQ-023 In PUBLISH, the FSM waits for a vblnk rising edge, detected as vblnk=1 while the registered vblnk_q=0.
REQ-024 On that vblnk edge cycle:
  - all DEPTH entries are copied to data (visible the next cycle);
  - frame_done pulses for exactly one cycle;
  - the FSM goes to WAIT_TRIG if run=1, otherwise to IDLE.
REQ-025 data changes only at the publish cycle, so the display never shows a partial trace.
  - vblnk edges outside PUBLISH are ignored.
REQ-026 sample_valid during PUBLISH or IDLE is discarded.
REQ-027 All counters are unsigned.
  - wr_idx is 8 bits and to_cnt is clog2(AUTO_TO) bits.
  - Threshold comparisons are 8-bit unsigned.

Reset
REQ-028 On rst, the following clear immediately and asynchronously:
  - state to IDLE;
  - data all entries 0x00;
  - internal buffer, prev and prev_valid to 0;
  - dec_cnt, to_cnt and wr_idx to 0;
  - vblnk_q, busy and frame_done to 0.
REQ-029 rst asserted mid-capture or mid-publish discards the partial trace; no frame_done is generated.

Structure
REQ-030 The capture state enum, DEPTH and the sample width constant SHALL live in vga_pkg beside the display constants.
REQ-031 Trigger comparison and prev tracking SHALL be one sub-module, trigger_detect.
  - Inputs: sample, take, level, rise, clear.
  - Output: hit.

Verification
REQ-032 Scenario 1, rising trigger: arm, run=0, decim=0, level=0x80, rise=1, ramp 0x00..0xFF one per cycle, then vblnk edge.
  - Required: data[0]=0x80, data[255]=0x7F (wrapped ramp), frame_done once, busy low after.
REQ-033 Scenario 2, decimation: decim=3, same ramp repeated.
  - Required: consecutive data entries differ by 4.
REQ-034 Scenario 3, auto trigger: auto_mode=1, constant sample 0x10, level 0x80, AUTO_TO=1024.
  - Required: CAPTURE entered on the 1024th taken sample; all data=0x10.
REQ-035 Scenario 4, publish wait: vblnk held low for 500 cycles after capture completes, then rises.
  - Required: data is unchanged until the edge and updates the cycle after it.
REQ-036 Scenario 5, falling trigger with run=1: level 0x40, rise=0, descending ramp over two frames.
  - Required: two frame_done pulses, and the FSM re-enters WAIT_TRIG without arm.
REQ-037 Scenario 6, reset mid-operation: rst at wr_idx=100.
  - Required: data all 0, state IDLE, no frame_done; a later arm captures normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA display chain and the trace capture
// block that feeds it.
package vga_pkg;

    // 640x480@60 display timing
    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    // Trace sample format and trace length (one sample per drawn column group)
    localparam int SAMPLE_W    = 8;
    localparam int TRACE_DEPTH = 256;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_PUBLISH
    } cap_state_t;

    // Threshold crossing between two consecutive taken samples, unsigned compare
    function automatic logic level_cross(sample_t prev, sample_t cur,
                                         sample_t level, logic rise);
        if (rise)
            return (prev < level) && (cur >= level);
        else
            return (prev > level) && (cur <= level);
    endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Control, sample and published-trace signals between the capture block and
// its producer/consumer (ADC front end, VGA timing, display drawer).
interface trace_capture_if #(
    parameter int DEPTH = vga_pkg::TRACE_DEPTH
);
    import vga_pkg::*;

    logic          sample_valid;
    sample_t       sample;
    sample_t       trig_level;
    logic          trig_rise;
    logic [7:0]    decim;
    logic          arm;
    logic          run;
    logic          auto_mode;
    logic          vblnk;
    sample_t       data [DEPTH];
    logic          busy;
    logic          frame_done;

    modport master (
        output sample_valid, sample, trig_level, trig_rise, decim,
               arm, run, auto_mode, vblnk,
        input  data, busy, frame_done
    );

    modport slave (
        input  sample_valid, sample, trig_level, trig_rise, decim,
               arm, run, auto_mode, vblnk,
        output data, busy, frame_done
    );

endinterface

// File: rtl/trigger_detect.sv
// Edge trigger on taken samples: remembers the previous taken sample and
// flags a threshold crossing on the current one.
module trigger_detect
    import vga_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t sample,
    input  logic    take,
    input  sample_t level,
    input  logic    rise,
    input  logic    clear,
    output logic    hit
);

    sample_t r_prev;
    logic    r_prev_valid;

    // Track the previous taken sample; clear forgets it so the next take only primes prev
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (clear) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (take) begin
            r_prev       <= sample;
            r_prev_valid <= 1'b1;
        end
    end

    // Crossing is judged on the current taken sample against the stored one
    always_comb begin
        hit = take && r_prev_valid && level_cross(r_prev, sample, level, rise);
    end

endmodule

// File: rtl/trace_capture.sv
// Triggered single/continuous trace capture into a private buffer, published
// to the display array only on a vertical-blank edge so a frame never shows a
// partially written trace.
module trace_capture
    import vga_pkg::*;
#(
    parameter int DEPTH   = TRACE_DEPTH,
    parameter int AUTO_TO = 1024
) (
    input  logic           clk,
    input  logic           rst,
    trace_capture_if.slave bus
);

    localparam int TO_W = $clog2(AUTO_TO);

    cap_state_t      r_state;
    cap_state_t      w_next;

    logic [7:0]      r_dec_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_wr_idx;
    sample_t         r_buf  [DEPTH];
    sample_t         r_data [DEPTH];
    logic            r_vblnk_q;
    logic            r_frame_done;

    logic            w_active;
    logic            w_take;
    logic            w_hit;
    logic            w_timeout;
    logic            w_trig;
    logic            w_last;
    logic            w_vb_edge;
    logic            w_publish;
    logic            w_enter_wait;

    trigger_detect u_trig (
        .clk    (clk),
        .rst    (rst),
        .sample (bus.sample),
        .take   (w_take && (r_state == S_WAIT_TRIG)),
        .level  (bus.trig_level),
        .rise   (bus.trig_rise),
        .clear  (w_enter_wait),
        .hit    (w_hit)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Sample qualification, trigger/timeout decode and next-state selection
    always_comb begin
        w_next       = r_state;
        w_active     = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
        w_take       = w_active && bus.sample_valid && (r_dec_cnt == 8'd0);
        w_timeout    = bus.auto_mode && (r_to_cnt == TO_W'(AUTO_TO - 1));
        w_trig       = 1'b0;
        w_last       = 1'b0;
        w_vb_edge    = bus.vblnk && !r_vblnk_q;
        w_publish    = 1'b0;
        w_enter_wait = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.arm) begin
                    w_next       = S_WAIT_TRIG;
                    w_enter_wait = 1'b1;
                end
            end
            S_WAIT_TRIG: begin
                // a timeout coinciding with a real hit is indistinguishable from the hit
                if (w_take && (w_hit || w_timeout)) begin
                    w_trig = 1'b1;
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_take && (r_wr_idx == 8'(DEPTH - 1))) begin
                    w_last = 1'b1;
                    w_next = S_PUBLISH;
                end
            end
            S_PUBLISH: begin
                if (w_vb_edge) begin
                    w_publish = 1'b1;
                    if (bus.run) begin
                        w_next       = S_WAIT_TRIG;
                        w_enter_wait = 1'b1;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Decimation, timeout and write-index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_cnt <= '0;
            r_to_cnt  <= '0;
            r_wr_idx  <= '0;
        end else begin
            if (w_enter_wait)
                r_dec_cnt <= '0;
            else if (w_active && bus.sample_valid)
                r_dec_cnt <= (r_dec_cnt == bus.decim) ? 8'd0 : r_dec_cnt + 8'd1;

            if (w_enter_wait)
                r_to_cnt <= '0;
            else if ((r_state == S_WAIT_TRIG) && w_take)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_trig)
                r_wr_idx <= 8'd1;
            else if ((r_state == S_CAPTURE) && w_take && !w_last)
                r_wr_idx <= r_wr_idx + 8'd1;
        end
    end

    // Private capture buffer: trigger sample at 0, then consecutive taken samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_buf[i] <= '0;
        end else if (w_trig) begin
            r_buf[0] <= bus.sample;
        end else if ((r_state == S_CAPTURE) && w_take) begin
            r_buf[r_wr_idx] <= bus.sample;
        end
    end

    // Published trace: whole-buffer copy on the vblank edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_data[i] <= '0;
        end else if (w_publish) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                r_data[i] <= r_buf[i];
        end
    end

    // Vblank edge history and the publish strobe, aligned with the new data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblnk_q    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_vblnk_q    <= bus.vblnk;
            r_frame_done <= w_publish;
        end
    end

    assign bus.data       = r_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboarded bench for trace_capture: a behavioural capture model queues the
// expected trace when the last sample is driven; each frame_done pops and
// compares the published array.
module tb_trace_capture;
    import vga_pkg::*;

    localparam int DEPTH   = 256;
    localparam int AUTO_TO = 1024;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    trace_capture_if #(.DEPTH(DEPTH)) bus ();

    trace_capture #(.DEPTH(DEPTH), .AUTO_TO(AUTO_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int fd_count = 0;

    // model state
    cap_state_t  m_st;
    logic [7:0]  m_dec;
    logic [7:0]  m_prev;
    bit          m_pv;
    int          m_to;
    int          m_wr;
    bit          m_vbq;
    logic [7:0]  m_buf [DEPTH];
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_st  = S_IDLE;
        m_dec = 8'd0;
        m_prev = 8'd0;
        m_pv  = 1'b0;
        m_to  = 0;
        m_wr  = 0;
        m_vbq = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_enter_wait();
        m_st  = S_WAIT_TRIG;
        m_dec = 8'd0;
        m_to  = 0;
        m_pv  = 1'b0;
    endfunction

    // Applies the inputs currently driven, as the DUT will at the next rising edge
    function automatic void model_step();
        bit take;
        bit hit;
        bit tmo;
        bit act;
        logic [7:0] s;
        logic [7:0] lv;
        s   = bus.sample;
        lv  = bus.trig_level;
        act = (m_st == S_WAIT_TRIG) || (m_st == S_CAPTURE);
        take = act && bus.sample_valid && (m_dec == 8'd0);
        if (act && bus.sample_valid)
            m_dec = (m_dec == bus.decim) ? 8'd0 : m_dec + 8'd1;
        case (m_st)
            S_IDLE: if (bus.arm) model_enter_wait();
            S_WAIT_TRIG: if (take) begin
                if (bus.trig_rise) hit = m_pv && (m_prev < lv) && (s >= lv);
                else               hit = m_pv && (m_prev > lv) && (s <= lv);
                tmo = bus.auto_mode && (m_to == AUTO_TO - 1);
                if (hit || tmo) begin
                    m_buf[0] = s;
                    m_wr     = 1;
                    m_st     = S_CAPTURE;
                end else begin
                    m_to   = (m_to + 1) % AUTO_TO;
                    m_prev = s;
                    m_pv   = 1'b1;
                end
            end
            S_CAPTURE: if (take) begin
                m_buf[m_wr] = s;
                if (m_wr == DEPTH - 1) begin
                    for (int i = 0; i < DEPTH; i++) exp_q.push_back(m_buf[i]);
                    m_st = S_PUBLISH;
                end else begin
                    m_wr++;
                end
            end
            S_PUBLISH: if (bus.vblnk && !m_vbq) begin
                if (bus.run) model_enter_wait();
                else         m_st = S_IDLE;
            end
            default: ;
        endcase
        m_vbq = bus.vblnk;
    endfunction

    task automatic tick(input logic v, input logic [7:0] s, input logic a, input logic vb);
        bus.sample_valid = v;
        bus.sample       = s;
        bus.arm          = a;
        bus.vblnk        = vb;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vblnk();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic run_until_publish(inout logic [7:0] s, input logic [7:0] step, input int budget);
        int n;
        n = 0;
        while (m_st != S_PUBLISH && n < budget) begin
            tick(1'b1, s, 1'b0, 1'b0);
            s = s + step;
            n++;
        end
        chk("reach_publish", 32'(dut.r_state), 32'(S_PUBLISH));
    endtask

    // Scoreboard: every frame_done consumes one expected trace
    always @(negedge clk) begin
        if (!rst && bus.frame_done) begin
            fd_count++;
            chk("fd_has_expected", 32'(exp_q.size() >= DEPTH), 32'd1);
            if (exp_q.size() >= DEPTH)
                for (int i = 0; i < DEPTH; i++)
                    chk($sformatf("data[%0d]", i), 32'(bus.data[i]), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        int fd0;
        int n;
        int nz;

        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample       = 8'h00;
        bus.trig_level   = 8'h80;
        bus.trig_rise    = 1'b1;
        bus.decim        = 8'd0;
        bus.arm          = 1'b0;
        bus.run          = 1'b0;
        bus.auto_mode    = 1'b0;
        bus.vblnk        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_data0", 32'(bus.data[0]), 32'd0);
        chk("rst_data255", 32'(bus.data[255]), 32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));

        // rising trigger, single shot
        fd0 = fd_count;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("s1_busy_armed", 32'(bus.busy), 32'd1);
        s = 8'h00;
        run_until_publish(s, 8'd1, 1000);
        pulse_vblnk();
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s1_fd_count", 32'(fd_count), 32'(fd0 + 1));
        chk("s1_data0", 32'(bus.data[0]), 32'h80);
        chk("s1_data255", 32'(bus.data[255]), 32'h7F);
        chk("s1_busy_after", 32'(bus.busy), 32'd0);

        // decimation by 4
        bus.decim = 8'd3;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = 8'h00;
        run_until_publish(s, 8'd1, 3000);
        pulse_vblnk();
        chk("s2_data0", 32'(bus.data[0]), 32'h80);
        chk("s2_data255", 32'(bus.data[255]), 32'h7C);
        for (int i = 0; i < 8; i++)
            chk($sformatf("s2_step[%0d]", i), 32'(8'(bus.data[i+1] - bus.data[i])), 32'd4);
        bus.decim = 8'd0;

        // auto trigger on a flat input
        bus.auto_mode = 1'b1;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < AUTO_TO - 1; i++) tick(1'b1, 8'h10, 1'b0, 1'b0);
        chk("s3_wait_before_to", 32'(dut.r_state), 32'(S_WAIT_TRIG));
        tick(1'b1, 8'h10, 1'b0, 1'b0);
        chk("s3_capture_at_to", 32'(dut.r_state), 32'(S_CAPTURE));
        s = 8'h10;
        run_until_publish(s, 8'd0, 1000);
        pulse_vblnk();
        chk("s3_data0", 32'(bus.data[0]), 32'h10);
        chk("s3_data255", 32'(bus.data[255]), 32'h10);
        bus.auto_mode = 1'b0;

        // long publish wait; samples offered meanwhile are discarded
        fd0 = fd_count;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = 8'h00;
        run_until_publish(s, 8'd1, 1000);
        for (int i = 0; i < 500; i++) begin
            tick(1'b1, 8'($urandom), 1'b0, 1'b0);
            if (i % 100 == 99) begin
                chk("s4_data_held", 32'(bus.data[0]), 32'h10);
                chk("s4_no_fd", 32'(fd_count), 32'(fd0));
            end
        end
        chk("s4_held_pre_edge", 32'(bus.data[255]), 32'h10);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4_data0_new", 32'(bus.data[0]), 32'h80);
        chk("s4_data255_new", 32'(bus.data[255]), 32'h7F);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s4_fd_count", 32'(fd_count), 32'(fd0 + 1));

        // falling trigger, continuous run
        bus.trig_level = 8'h40;
        bus.trig_rise  = 1'b0;
        bus.run        = 1'b1;
        fd0 = fd_count;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        pulse_vblnk();
        chk("s5_vblnk_ignored", 32'(fd_count), 32'(fd0));
        s = 8'hFF;
        run_until_publish(s, 8'hFF, 1000);
        pulse_vblnk();
        chk("s5_fd1", 32'(fd_count), 32'(fd0 + 1));
        chk("s5_rearm_state", 32'(dut.r_state), 32'(S_WAIT_TRIG));
        chk("s5_rearm_busy", 32'(bus.busy), 32'd1);
        run_until_publish(s, 8'hFF, 1000);
        pulse_vblnk();
        chk("s5_fd2", 32'(fd_count), 32'(fd0 + 2));
        chk("s5_rearm_state2", 32'(dut.r_state), 32'(S_WAIT_TRIG));
        chk("s5_data0", 32'(bus.data[0]), 32'h40);
        chk("s5_data255", 32'(bus.data[255]), 32'h41);
        bus.run = 1'b0;

        // reset in the middle of a capture
        bus.trig_level = 8'h80;
        bus.trig_rise  = 1'b1;
        fd0 = fd_count;
        s = 8'h00;
        n = 0;
        while (!(m_st == S_CAPTURE && m_wr == 100) && n < 1000) begin
            tick(1'b1, s, 1'b0, 1'b0);
            s = s + 8'd1;
            n++;
        end
        chk("s6_wr_idx_pre", 32'(dut.r_wr_idx), 32'd100);
        rst = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (bus.data[i] !== 8'h00) nz++;
        chk("s6_data_cleared", 32'(nz), 32'd0);
        chk("s6_state_idle", 32'(dut.r_state), 32'(S_IDLE));
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_frame_done", 32'(bus.frame_done), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) tick(1'b1, 8'(i), 1'b0, (i == 10) ? 1'b1 : 1'b0);
        chk("s6_no_fd", 32'(fd_count), 32'(fd0));
        chk("s6_idle_after", 32'(dut.r_state), 32'(S_IDLE));
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        s = 8'h00;
        run_until_publish(s, 8'd1, 1000);
        pulse_vblnk();
        chk("s6_fd_after", 32'(fd_count), 32'(fd0 + 1));
        chk("s6_data0", 32'(bus.data[0]), 32'h80);
        chk("s6_data255", 32'(bus.data[255]), 32'h7F);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
